fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences instruction fetch for the out-of-order core: owns the PC and issues one fetch request at a time to the memory/icache port.
- Runs each returned word through the static jump predictor to choose the next PC, then hands the instruction to the instruction queue.
- Handles back-pressure from a full queue, and ROB rollback, including squashing an in-flight fetch.

Parameters:
- ADDR_WIDTH, 32, PC / address width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy_in  in  1  global ready; when 0 all state holds and no new request is raised.
- mem_req_valid  out  1  fetch request.
- mem_req_addr  out  ADDR_WIDTH  fetch address.
- mem_req_ready  in  1  request accepted this cycle.
- mem_resp_valid  in  1  fetched word valid (one cycle pulse).
- mem_resp_inst  in  INST_WIDTH  fetched word.
- iq_full  in  1  instruction queue cannot accept.
- issue_valid  out  1  instruction delivered this cycle.
- issue_inst  out  INST_WIDTH  instruction.
- issue_pc  out  ADDR_WIDTH  its PC.
- issue_pred_jump  out  1  predictor said taken.
- issue_pred_pc  out  ADDR_WIDTH  predicted next PC.
- rollback  in  1  ROB misprediction flush.
- rollback_pc  in  ADDR_WIDTH  redirect target.

Behaviour:
- Clock and reset: single clock, clk; asynchronous active-low reset, rst_n.
- Reset values:
  - state=REQ, pc=RESET_PC.
  - mem_req_valid=0, issue_valid=0.
  - issue_* data and mem_req_addr = 0.
- States:
  - REQ: drive mem_req_valid=1, mem_req_addr=pc; on mem_req_ready go to WAIT.
  - WAIT: waiting for response. On mem_resp_valid capture the word into inst_buf/pc_buf and go to HOLD.
  - HOLD: word captured.
    - If !iq_full: assert issue_valid for exactly 1 cycle; issue_pc=pc_buf; issue_pred_jump/issue_pred_pc from the predictor.
    - Next pc = pc_buf+pred_imm if the predictor says jump, else pc_buf+4 (modulo 2^ADDR_WIDTH, wrap silently).
    - Go to REQ; the new request appears the cycle after the issue.
    - If iq_full: stay in HOLD, no issue.
  - SQUASH: a request was accepted but rollback arrived first. Wait for mem_resp_valid, drop the word, then go to REQ with pc already = rollback_pc.
- Predictor: the query PC/inst is always pc_buf/inst_buf. The predictor is combinational; outputs are registered into issue_* on the issue cycle.
- Latency: req accept -> resp (N cycles, memory-defined) -> issue no earlier than 1 cycle after resp. Minimum loop is 3 cycles per instruction.
- Rollback (highest priority, any state): pc<=rollback_pc and issue_valid<=0 that cycle.
  - REQ without accept: state stays REQ. A same-cycle mem_req_ready is treated as accepted → SQUASH.
  - WAIT: → SQUASH, unless mem_resp_valid is the same cycle, then the word is dropped → REQ.
  - HOLD: buffered word discarded → REQ.
  - SQUASH: stay SQUASH, pc updated.
- Never more than one outstanding memory request.
- mem_req_valid is held stable with a constant address until accepted or rollback.
- rdy_in=0: freeze state, pc and buffers. mem_req_valid is driven 0; issue_valid is driven 0. A mem_resp_valid pulse arriving while rdy_in=0 is still captured (memory cannot be stalled).
- Reset mid-operation: immediate return to reset values. Any in-flight response after reset release while in REQ is ignored (mem_resp_valid is only looked at in WAIT/SQUASH).

Decomposition:
- Shared defines header: ADDR/INST widths, OPCODE_RANGE, OPCODE_JAL, and the 2-bit state encodings (REQ=0, WAIT=1, HOLD=2, SQUASH=3).
- One sub-module: the existing static predictor, instantiated as u_predictor. No other sub-modules.

Test Plan:
- Reset, then memory returns ADDI (0x00100093) at 0 with 2-cycle latency, iq_full=0 → issue_valid pulse with issue_pc=0, pred_jump=0, pred_pc=4; next mem_req_addr=4.
- JAL x0,+16 (0x0100006F) fetched at 0x8 → issue_pred_jump=1, issue_pred_pc=0x18; next mem_req_addr=0x18. JAL -8 (0xFF9FF06F) at 0x8 → next addr 0x0.
- Word returned while iq_full=1 for 5 cycles → no issue_valid and no new mem_req_valid during the stall; issue occurs the cycle after iq_full falls.
- Rollback to 0x100 one cycle after request acceptance → the stale response is dropped, no issue_valid; next mem_req_addr=0x100.
- Rollback in the same cycle as mem_resp_valid → word dropped; next request to rollback_pc. Rollback in HOLD with iq_full=1 → buffer cleared, request to rollback_pc.
- PC at 0xFFFFFFFC, non-jump → next fetch address 0x0. Assert rst_n low while in WAIT → mem_req_valid=0 and pc=RESET_PC immediately (async).

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch slice: widths, opcode field, FSM encoding.
// Includes the J-type immediate decoder used by the static predictor.
package fetch_controller_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam logic [6:0] OPCODE_JAL = 7'b110_1111;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } fc_state_e;

    // upper = inst[31:12]; returns the byte offset imm[20:0] with imm[0] = 0
    function automatic logic [20:0] jal_imm(input logic [19:0] upper);
        return {upper[19], upper[7:0], upper[8], upper[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Memory request/response, instruction-queue issue and ROB rollback signals of the fetch unit.
// master = fetch controller, slave = memory / queue / ROB side.
interface fetch_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) ();

    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [INST_WIDTH-1:0] mem_resp_inst;
    logic                  iq_full;
    logic                  issue_valid;
    logic [INST_WIDTH-1:0] issue_inst;
    logic [ADDR_WIDTH-1:0] issue_pc;
    logic                  issue_pred_jump;
    logic [ADDR_WIDTH-1:0] issue_pred_pc;
    logic                  rollback;
    logic [ADDR_WIDTH-1:0] rollback_pc;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_inst,
        input  iq_full,
        output issue_valid, issue_inst, issue_pc, issue_pred_jump, issue_pred_pc,
        input  rollback, rollback_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_inst,
        output iq_full,
        input  issue_valid, issue_inst, issue_pc, issue_pred_jump, issue_pred_pc,
        output rollback, rollback_pc
    );

endinterface

// File: rtl/fetch_controller_predictor.sv
// Static jump predictor: JAL is always taken, everything else falls through to pc+4.
// Purely combinational, no backpressure.
module fetch_controller_predictor
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [19:0]           upper,
    input  logic [6:0]            opcode,
    output logic                  pred_jump,
    output logic [ADDR_WIDTH-1:0] pred_pc
);

    logic [20:0]           imm;
    logic [ADDR_WIDTH-1:0] imm_ext;

    assign imm       = jal_imm(upper);
    assign imm_ext   = {{(ADDR_WIDTH-21){imm[20]}}, imm};
    assign pred_jump = (opcode == OPCODE_JAL);
    // address arithmetic wraps modulo 2^ADDR_WIDTH
    assign pred_pc   = pc + (pred_jump ? imm_ext : ADDR_WIDTH'(4));

endmodule

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch sequencer with static jump prediction and ROB rollback.
// Min 3 cycles/instruction; a full queue parks the word in HOLD, rdy_in=0 freezes all but response capture.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    INST_WIDTH = INST_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy_in,
    fetch_controller_if.master        bus
);

    fc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  req_q;
    logic [ADDR_WIDTH-1:0] pc_buf_q;
    logic [INST_WIDTH-1:0] inst_buf_q;
    logic                  capture;
    logic                  issue_fire;
    logic                  accept;

    logic                  issue_valid_q;
    logic [INST_WIDTH-1:0] issue_inst_q;
    logic [ADDR_WIDTH-1:0] issue_pc_q;
    logic                  issue_pred_jump_q;
    logic [ADDR_WIDTH-1:0] issue_pred_pc_q;

    logic                  pred_jump;
    logic [ADDR_WIDTH-1:0] pred_pc;

    fetch_controller_predictor #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_predictor (
        .pc        (pc_buf_q),
        .upper     (inst_buf_q[31:12]),
        .opcode    (inst_buf_q[OPCODE_MSB:OPCODE_LSB]),
        .pred_jump (pred_jump),
        .pred_pc   (pred_pc)
    );

    assign accept = req_q && rdy_in && bus.mem_req_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        capture    = 1'b0;
        issue_fire = 1'b0;
        if (rdy_in && bus.rollback) begin
            pc_d = bus.rollback_pc;
            case (state_q)
                ST_REQ:  state_d = accept ? ST_SQUASH : ST_REQ;
                ST_WAIT: state_d = bus.mem_resp_valid ? ST_REQ : ST_SQUASH;
                ST_HOLD: state_d = ST_REQ;
                default: state_d = ST_SQUASH;
            endcase
        end else begin
            // Responses are consumed even when frozen: memory cannot be stalled.
            case (state_q)
                ST_REQ: begin
                    if (accept) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rdy_in && !bus.iq_full) begin
                        issue_fire = 1'b1;
                        pc_d       = pred_pc;
                        state_d    = ST_REQ;
                    end
                end
                default: begin
                    if (bus.mem_resp_valid) state_d = ST_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_REQ;
            pc_q              <= RESET_PC;
            addr_q            <= '0;
            req_q             <= 1'b0;
            pc_buf_q          <= '0;
            inst_buf_q        <= '0;
            issue_valid_q     <= 1'b0;
            issue_inst_q      <= '0;
            issue_pc_q        <= '0;
            issue_pred_jump_q <= 1'b0;
            issue_pred_pc_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            // request is raised together with the issue pulse, so the loop closes in 3 cycles
            addr_q        <= pc_d;
            req_q         <= (state_d == ST_REQ);
            issue_valid_q <= issue_fire;
            if (capture) begin
                pc_buf_q   <= pc_q;
                inst_buf_q <= bus.mem_resp_inst;
            end
            if (issue_fire) begin
                issue_inst_q      <= inst_buf_q;
                issue_pc_q        <= pc_buf_q;
                issue_pred_jump_q <= pred_jump;
                issue_pred_pc_q   <= pred_pc;
            end
        end
    end

    assign bus.mem_req_valid   = req_q && rdy_in;
    assign bus.mem_req_addr    = addr_q;
    assign bus.issue_valid     = issue_valid_q;
    assign bus.issue_inst      = issue_inst_q;
    assign bus.issue_pc        = issue_pc_q;
    assign bus.issue_pred_jump = issue_pred_jump_q;
    assign bus.issue_pred_pc   = issue_pred_pc_q;

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_req_valid && !bus.mem_req_ready && !bus.rollback |=> $stable(bus.mem_req_addr));

    a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_req_valid |-> (state_q == ST_REQ));

    a_issue_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        bus.issue_valid |=> !bus.issue_valid);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a transaction-level reference model checked every cycle.
module tb_fetch_controller;

    logic clk;
    logic rst_n;
    logic rdy_in;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_controller_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

    fetch_controller #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding fetch, one buffered word, expected next fetch address.
    logic        m_out, m_sq, m_pend, m_will;
    logic [31:0] m_addr, m_fpc;
    logic [31:0] m_inst, m_pc, m_ppc, m_jimm;
    logic        m_jump;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_req_valid", bus.mem_req_valid, 0);
            chk("reset_issue_valid", bus.issue_valid, 0);
            m_out = 0; m_sq = 0; m_pend = 0; m_will = 0;
            m_addr = 32'h0;
        end else begin
            chk("issue_valid", bus.issue_valid, m_will);
            if (bus.issue_valid && m_pend) begin
                chk("issue_inst", bus.issue_inst, m_inst);
                chk("issue_pc", bus.issue_pc, m_pc);
                chk("issue_pred_jump", bus.issue_pred_jump, m_jump);
                chk("issue_pred_pc", bus.issue_pred_pc, m_ppc);
                m_pend = 0;
                m_addr = m_ppc;
            end
            m_will = m_pend && !bus.iq_full && rdy_in && !bus.rollback;

            if (bus.mem_req_valid) begin
                chk("req_addr", bus.mem_req_addr, m_addr);
                chk("req_while_busy", {m_out, m_pend}, 0);
                chk("req_while_frozen", rdy_in, 1);
                if (bus.mem_req_ready) begin
                    m_out = 1; m_sq = 0; m_fpc = bus.mem_req_addr;
                end
            end

            if (rdy_in && bus.rollback) begin
                if (m_out) m_sq = 1;
                m_pend = 0;
                m_will = 0;
                m_addr = bus.rollback_pc;
            end

            if (bus.mem_resp_valid && m_out) begin
                m_out = 0;
                if (!m_sq) begin
                    m_pend = 1;
                    m_inst = bus.mem_resp_inst;
                    m_pc   = m_fpc;
                    m_jump = (m_inst[6:0] == 7'h6F);
                    m_jimm = {{11{m_inst[31]}}, m_inst[31], m_inst[19:12], m_inst[20],
                              m_inst[30:21], 1'b0};
                    m_ppc  = m_pc + (m_jump ? m_jimm : 32'd4);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] exp, input string name);
        int n = 0;
        while (!bus.mem_req_valid && n < 40) begin
            step();
            n++;
        end
        chk({name, "_seen"}, bus.mem_req_valid, 1);
        chk(name, bus.mem_req_addr, exp);
    endtask

    task automatic accept_req();
        int n = 0;
        while (!bus.mem_req_valid && n < 40) begin
            step();
            n++;
        end
        chk("accept_seen", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] inst, input int gap);
        repeat (gap) step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_inst  = inst;
        step();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        while (!bus.issue_valid && n < 40) begin
            step();
            n++;
        end
        chk(name, bus.issue_valid, 1);
    endtask

    task automatic do_rollback(input logic [31:0] target);
        bus.rollback    = 1'b1;
        bus.rollback_pc = target;
        step();
        bus.rollback    = 1'b0;
    endtask

    task automatic quiet(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            chk(name, bus.issue_valid, 0);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        rdy_in             = 1'b1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_inst  = '0;
        bus.iq_full        = 1'b0;
        bus.rollback       = 1'b0;
        bus.rollback_pc    = '0;
        repeat (2) step();
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
        chk("rst_issue_pc", bus.issue_pc, 32'h0);
        chk("rst_issue_inst", bus.issue_inst, 32'h0);
        rst_n = 1'b1;

        // ADDI at 0, 2-cycle memory latency
        wait_req(32'h0, "first_req_addr");
        accept_req();
        respond(32'h0010_0093, 1);
        wait_issue("addi_issue");
        chk("addi_pc", bus.issue_pc, 32'h0);
        chk("addi_pred_jump", bus.issue_pred_jump, 0);
        chk("addi_pred_pc", bus.issue_pred_pc, 32'h4);
        chk("addi_inst", bus.issue_inst, 32'h0010_0093);
        wait_req(32'h4, "after_addi_addr");

        accept_req();
        respond(32'h0010_0093, 0);
        wait_req(32'h8, "to_8_addr");

        // JAL x0,+16 at 0x8
        accept_req();
        respond(32'h0100_006F, 1);
        wait_issue("jal_fwd_issue");
        chk("jal_fwd_jump", bus.issue_pred_jump, 1);
        chk("jal_fwd_pred_pc", bus.issue_pred_pc, 32'h18);
        wait_req(32'h18, "jal_fwd_next_addr");

        // rollback while a request waits unaccepted, then JAL -8 at 0x8
        do_rollback(32'h8);
        wait_req(32'h8, "rollback_req_addr");
        accept_req();
        respond(32'hFF9F_F06F, 2);
        wait_issue("jal_back_issue");
        chk("jal_back_jump", bus.issue_pred_jump, 1);
        chk("jal_back_pred_pc", bus.issue_pred_pc, 32'h0);
        wait_req(32'h0, "jal_back_next_addr");

        // full instruction queue for 5 cycles
        bus.iq_full = 1'b1;
        accept_req();
        respond(32'h0020_0113, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_issue", bus.issue_valid, 0);
            chk("stall_no_req", bus.mem_req_valid, 0);
            step();
        end
        bus.iq_full = 1'b0;
        step();
        chk("stall_release_issue", bus.issue_valid, 1);
        chk("stall_release_pc", bus.issue_pc, 32'h0);
        wait_req(32'h4, "stall_next_addr");

        // rollback one cycle after acceptance: stale word dropped
        accept_req();
        do_rollback(32'h100);
        respond(32'h0030_0193, 1);
        quiet(3, "squash_no_issue");
        wait_req(32'h100, "squash_next_addr");

        // rollback in the response cycle
        accept_req();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_inst  = 32'h0040_0213;
        bus.rollback       = 1'b1;
        bus.rollback_pc    = 32'h200;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.rollback       = 1'b0;
        quiet(2, "resp_rb_no_issue");
        wait_req(32'h200, "resp_rb_next_addr");

        // rollback while holding a word behind a full queue
        bus.iq_full = 1'b1;
        accept_req();
        respond(32'h0050_0293, 0);
        repeat (2) step();
        do_rollback(32'h300);
        bus.iq_full = 1'b0;
        quiet(3, "hold_rb_no_issue");
        wait_req(32'h300, "hold_rb_next_addr");

        // PC wrap at the top of the address space
        do_rollback(32'hFFFF_FFFC);
        wait_req(32'hFFFF_FFFC, "wrap_req_addr");
        accept_req();
        respond(32'h0010_0093, 1);
        wait_issue("wrap_issue");
        chk("wrap_pred_pc", bus.issue_pred_pc, 32'h0);
        wait_req(32'h0, "wrap_next_addr");

        // response captured while globally frozen
        accept_req();
        rdy_in = 1'b0;
        respond(32'h0060_0313, 1);
        for (int i = 0; i < 3; i++) begin
            chk("frozen_no_issue", bus.issue_valid, 0);
            chk("frozen_no_req", bus.mem_req_valid, 0);
            step();
        end
        rdy_in = 1'b1;
        step();
        chk("unfreeze_issue", bus.issue_valid, 1);
        chk("unfreeze_inst", bus.issue_inst, 32'h0060_0313);
        wait_req(32'h4, "unfreeze_next_addr");

        // asynchronous reset while waiting for a response
        accept_req();
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", bus.mem_req_valid, 0);
        chk("async_rst_req_addr", bus.mem_req_addr, 32'h0);
        chk("async_rst_issue_pc", bus.issue_pc, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        respond(32'h0100_006F, 0);
        quiet(2, "post_rst_no_issue");
        wait_req(32'h0, "post_rst_addr");
        accept_req();
        respond(32'h0010_0093, 1);
        wait_issue("post_rst_issue");
        chk("post_rst_issue_pc", bus.issue_pc, 32'h0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
